// File: rtl/alu_issue_pkg.sv
// Shared definitions for the ALU issue stage.
// - RV32I opcode and funct7 constants used by the decoder.
// - issue_t: one skid-buffer entry. It holds the ALU payload and the
//   source tags needed to forward late writebacks into buffered operands.
// - buf_state_e: occupancy of the 2-entry skid buffer.
// - forward_wb: applies a writeback to an entry's register-sourced operands.
package alu_issue_pkg;

  localparam int XLEN = 32;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] F7_BASE    = 7'b0000000;
  localparam logic [6:0] F7_ALT     = 7'b0100000;

  typedef enum logic [1:0] {
    BUF_EMPTY = 2'd0,
    BUF_ONE   = 2'd1,
    BUF_TWO   = 2'd2
  } buf_state_e;

  typedef struct packed {
    logic [XLEN-1:0] in1;
    logic [XLEN-1:0] in2;
    logic [4:0]      shamt;
    logic            use_shamt;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic            rs1_reg;
    logic            rs2_reg;
  } issue_t;

  // Replace any operand that was read from the register being written.
  // x0 is never forwarded because writes to it are discarded. Immediate
  // operands have their from-reg flag clear, so they are never touched.
  function automatic issue_t forward_wb(input issue_t          e,
                                        input logic            wb_en,
                                        input logic [4:0]      wb_rd,
                                        input logic [XLEN-1:0] wb_data);
    issue_t r;
    r = e;
    if (wb_en && (wb_rd != 5'd0)) begin
      if (e.rs1_reg && (e.rs1 == wb_rd)) r.in1 = wb_data;
      if (e.rs2_reg && (e.rs2 == wb_rd)) r.in2 = wb_data;
    end
    return r;
  endfunction

endpackage

// File: rtl/alu_issue_if.sv
// Bundle of the ALU issue stage's data-path signals.
// - instr_*  : instruction handshake from fetch (valid/ready + 32-bit word)
// - wb_*     : register writeback port
// - issue_*  : handshake toward the ALU, plus its operand/control payload
// - illegal  : one-cycle pulse for an accepted, non-issued instruction
// master = the surrounding pipeline (drives instructions, writebacks and
// ALU ready); slave = the issue stage itself.
interface alu_issue_if;
  import alu_issue_pkg::*;

  logic            instr_valid;
  logic            instr_ready;
  logic [31:0]     instr;

  logic            wb_en;
  logic [4:0]      wb_rd;
  logic [XLEN-1:0] wb_data;

  logic            issue_valid;
  logic            issue_ready;
  logic [XLEN-1:0] in1;
  logic [XLEN-1:0] in2;
  logic [4:0]      shamt;
  logic            use_shamt;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [4:0]      rd;
  logic            illegal;

  modport master (
    output instr_valid, instr, wb_en, wb_rd, wb_data, issue_ready,
    input  instr_ready, issue_valid, in1, in2, shamt, use_shamt,
           funct3, funct7, rd, illegal
  );

  modport slave (
    input  instr_valid, instr, wb_en, wb_rd, wb_data, issue_ready,
    output instr_ready, issue_valid, in1, in2, shamt, use_shamt,
           funct3, funct7, rd, illegal
  );

endinterface

// File: rtl/alu_issue_regfile.sv
// Architectural register file: 32 x XLEN, two asynchronous read ports and
// one write port.
// - clk, rst_n        : clock, asynchronous active-low reset (clears all)
// - we/waddr/wdata    : write port; writes to x0 are dropped
// - raddr_a/raddr_b   : read addresses; x0 always reads as zero
// - rdata_a/rdata_b   : read data, optionally bypassing a same-cycle write
module alu_issue_regfile
  import alu_issue_pkg::*;
#(
  parameter bit BYPASS_WB = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            we,
  input  logic [4:0]      waddr,
  input  logic [XLEN-1:0] wdata,
  input  logic [4:0]      raddr_a,
  input  logic [4:0]      raddr_b,
  output logic [XLEN-1:0] rdata_a,
  output logic [XLEN-1:0] rdata_b
);

  logic [XLEN-1:0] regs_q [32];
  logic [XLEN-1:0] regs_d [32];

  // Next register contents: only a nonzero destination is written, so
  // x0 stays zero forever.
  always_comb begin
    regs_d = regs_q;
    if (we && (waddr != 5'd0)) regs_d[waddr] = wdata;
  end

  // Storage, cleared on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) regs_q[i] <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  // Read ports. With bypass enabled, a write landing this cycle is visible
  // immediately, so a consumer reading in the same cycle is not stale.
  always_comb begin
    rdata_a = '0;
    rdata_b = '0;
    if (raddr_a != 5'd0) begin
      if (BYPASS_WB && we && (waddr == raddr_a)) rdata_a = wdata;
      else                                       rdata_a = regs_q[raddr_a];
    end
    if (raddr_b != 5'd0) begin
      if (BYPASS_WB && we && (waddr == raddr_b)) rdata_b = wdata;
      else                                       rdata_b = regs_q[raddr_b];
    end
  end

endmodule

// File: rtl/alu_issue.sv
// Decode/issue stage feeding the ALU.
// - clk, rst_n : clock, asynchronous active-low reset
// - bus        : alu_issue_if slave port
//     instr_valid/instr_ready/instr : RV32 OP / OP-IMM instruction input
//     wb_en/wb_rd/wb_data           : register writeback
//     issue_valid/issue_ready       : head-of-buffer handshake to the ALU
//     in1/in2/shamt/use_shamt/funct3/funct7/rd : ALU payload
//     illegal                       : pulse, accepted but not issued
// Decodes the instruction, reads operands from the owned register file and
// holds up to two decoded entries in a skid buffer. Buffered operands keep
// tracking writebacks so they never go stale while the ALU stalls.
module alu_issue
  import alu_issue_pkg::*;
#(
  parameter int XLEN_P    = XLEN,
  parameter bit BYPASS_WB = 1'b1
) (
  input  logic  clk,
  input  logic  rst_n,
  alu_issue_if.slave bus
);

  buf_state_e state_q, state_d;
  issue_t     e0_q, e0_d;
  issue_t     e1_q, e1_d;
  logic       illegal_q, illegal_d;

  issue_t            new_e;
  logic              legal;
  logic [XLEN_P-1:0] rdata_a;
  logic [XLEN_P-1:0] rdata_b;
  issue_t            e0_fwd;
  issue_t            e1_fwd;
  logic              accept;
  logic              consume;
  logic              push;

  logic [6:0] opcode;
  logic [2:0] f3;
  logic [6:0] f7;

  assign opcode = bus.instr[6:0];
  assign f3     = bus.instr[14:12];
  assign f7     = bus.instr[31:25];

  alu_issue_regfile #(.BYPASS_WB(BYPASS_WB)) u_regfile (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (bus.wb_en),
    .waddr   (bus.wb_rd),
    .wdata   (bus.wb_data),
    .raddr_a (bus.instr[19:15]),
    .raddr_b (bus.instr[24:20]),
    .rdata_a (rdata_a),
    .rdata_b (rdata_b)
  );

  // Decode the offered instruction into a buffer entry and decide whether
  // it is legal. OP-IMM arithmetic other than the shifts has its funct7
  // forced to zero so that bit 30 of the immediate never turns ADDI into SUB.
  always_comb begin
    new_e         = '0;
    legal         = 1'b0;
    new_e.rd      = bus.instr[11:7];
    new_e.rs1     = bus.instr[19:15];
    new_e.rs1_reg = 1'b1;
    new_e.in1     = rdata_a;
    new_e.funct3  = f3;
    case (opcode)
      OPC_OP: begin
        new_e.rs2     = bus.instr[24:20];
        new_e.rs2_reg = 1'b1;
        new_e.in2     = rdata_b;
        new_e.funct7  = f7;
        legal = (f7 == F7_BASE) ||
                ((f7 == F7_ALT) && ((f3 == 3'b000) || (f3 == 3'b101)));
      end
      OPC_OP_IMM: begin
        new_e.in2   = {{20{bus.instr[31]}}, bus.instr[31:20]};
        new_e.shamt = bus.instr[24:20];
        if (f3 == 3'b001) begin
          new_e.use_shamt = 1'b1;
          new_e.funct7    = f7;
          legal           = (f7 == F7_BASE);
        end else if (f3 == 3'b101) begin
          new_e.use_shamt = 1'b1;
          new_e.funct7    = f7;
          legal           = (f7 == F7_BASE) || (f7 == F7_ALT);
        end else begin
          new_e.funct7 = F7_BASE;
          legal        = 1'b1;
        end
      end
      default: legal = 1'b0;
    endcase
  end

  // Held entries with this cycle's writeback already applied. These feed
  // both the outputs and the next-state logic, so a value written while the
  // ALU is stalled is seen immediately and then retained.
  always_comb begin
    e0_fwd = forward_wb(e0_q, bus.wb_en, bus.wb_rd, bus.wb_data);
    e1_fwd = forward_wb(e1_q, bus.wb_en, bus.wb_rd, bus.wb_data);
  end

  assign bus.instr_ready = rst_n && (state_q != BUF_TWO);
  assign bus.issue_valid = (state_q != BUF_EMPTY);
  assign accept          = bus.instr_valid && bus.instr_ready;
  assign consume         = bus.issue_valid && bus.issue_ready;
  assign push            = accept && legal;

  // Skid buffer control. e0 is always the head. Illegal instructions are
  // swallowed here and only raise the illegal pulse for the next cycle.
  // In TWO the input is stalled, so a consume there only shifts e1 up.
  always_comb begin
    state_d   = state_q;
    e0_d      = e0_fwd;
    e1_d      = e1_fwd;
    illegal_d = accept && !legal;
    case (state_q)
      BUF_EMPTY: begin
        if (push) begin
          e0_d    = new_e;
          state_d = BUF_ONE;
        end
      end
      BUF_ONE: begin
        if (push && consume) begin
          e0_d = new_e;
        end else if (push) begin
          e1_d    = new_e;
          state_d = BUF_TWO;
        end else if (consume) begin
          state_d = BUF_EMPTY;
        end
      end
      BUF_TWO: begin
        if (consume) begin
          e0_d    = e1_fwd;
          state_d = BUF_ONE;
        end
      end
      default: state_d = BUF_EMPTY;
    endcase
  end

  // Buffer registers. Reset throws away both entries and any pending
  // illegal pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= BUF_EMPTY;
      e0_q      <= '0;
      e1_q      <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      e0_q      <= e0_d;
      e1_q      <= e1_d;
      illegal_q <= illegal_d;
    end
  end

  // Payload is forced to zero whenever nothing is being offered.
  always_comb begin
    bus.in1       = '0;
    bus.in2       = '0;
    bus.shamt     = '0;
    bus.use_shamt = 1'b0;
    bus.funct3    = '0;
    bus.funct7    = '0;
    bus.rd        = '0;
    if (state_q != BUF_EMPTY) begin
      bus.in1       = e0_fwd.in1;
      bus.in2       = e0_fwd.in2;
      bus.shamt     = e0_fwd.shamt;
      bus.use_shamt = e0_fwd.use_shamt;
      bus.funct3    = e0_fwd.funct3;
      bus.funct7    = e0_fwd.funct7;
      bus.rd        = e0_fwd.rd;
    end
  end

  assign bus.illegal = illegal_q;

endmodule

// File: tb/tb_alu_issue.sv
// Self-checking bench for alu_issue. Stimulus pushes the hand-computed
// expected ALU payload into a scoreboard queue when an instruction is
// accepted; a monitor pops and compares whenever the DUT hands an entry to
// the ALU, and tracks expected illegal pulses separately.
module tb_alu_issue;

  typedef struct packed {
    logic [31:0] in1;
    logic [31:0] in2;
    logic [4:0]  shamt;
    logic        use_shamt;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rd;
  } exp_t;

  logic clk;
  logic rst_n;
  alu_issue_if bus ();

  alu_issue #(.BYPASS_WB(1'b1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  exp_t exp_q[$];
  int   ill_pending = 0;
  int   n_checks = 0;
  int   n_pass = 0;

  // Free-running clock, 10 time units per cycle.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop so the bench cannot hang.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic exp_t mk(input logic [31:0] in1, input logic [31:0] in2,
                              input logic [4:0] shamt, input logic use_shamt,
                              input logic [2:0] funct3, input logic [6:0] funct7,
                              input logic [4:0] rd);
    exp_t e;
    e.in1 = in1; e.in2 = in2; e.shamt = shamt; e.use_shamt = use_shamt;
    e.funct3 = funct3; e.funct7 = funct7; e.rd = rd;
    return e;
  endfunction

  task automatic checkOutput(input string name, input logic [95:0] act,
                             input logic [95:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one instruction and wait (bounded) until it is accepted.
  task automatic applyStimulus(input logic [31:0] w, input bit legal,
                               input exp_t e);
    int waited;
    waited = 0;
    bus.instr       = w;
    bus.instr_valid = 1'b1;
    @(negedge clk);
    while (!bus.instr_ready && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    if (!bus.instr_ready) begin
      checkOutput("accept_timeout", 96'(bus.instr_ready), 96'd1);
    end else if (legal) begin
      exp_q.push_back(e);
    end else begin
      ill_pending++;
    end
    tick();
    bus.instr_valid = 1'b0;
  endtask

  task automatic writeReg(input logic [4:0] r, input logic [31:0] d);
    bus.wb_en   = 1'b1;
    bus.wb_rd   = r;
    bus.wb_data = d;
    tick();
    bus.wb_en   = 1'b0;
  endtask

  task automatic waitDrain();
    int c;
    c = 0;
    while ((exp_q.size() != 0 || ill_pending != 0) && c < 200) begin
      @(posedge clk);
      c++;
    end
    #1;
    checkOutput("drain", 96'(exp_q.size() + ill_pending), 96'd0);
  endtask

  // Monitor: compare the head entry on every ALU transfer and account for
  // every illegal pulse cycle.
  initial begin
    exp_t act;
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (bus.issue_valid && bus.issue_ready) begin
          act = {bus.in1, bus.in2, bus.shamt, bus.use_shamt,
                 bus.funct3, bus.funct7, bus.rd};
          if (exp_q.size() == 0) begin
            checkOutput("unexpected_issue", 96'(bus.issue_valid), 96'd0);
          end else begin
            e = exp_q.pop_front();
            checkOutput($sformatf("issue_rd%0d", e.rd), 96'(act), 96'(e));
          end
        end
        if (bus.illegal) begin
          checkOutput("illegal_pulse", 96'(bus.illegal), 96'(ill_pending > 0));
          if (ill_pending > 0) ill_pending--;
        end
      end
    end
  end

  initial begin
    logic [31:0] w;
    bus.instr_valid = 1'b0;
    bus.instr       = '0;
    bus.wb_en       = 1'b0;
    bus.wb_rd       = '0;
    bus.wb_data     = '0;
    bus.issue_ready = 1'b1;
    rst_n           = 1'b0;

    // Reset state
    #3;
    checkOutput("reset_issue_valid", 96'(bus.issue_valid), 96'd0);
    checkOutput("reset_illegal", 96'(bus.illegal), 96'd0);
    checkOutput("reset_in1", 96'(bus.in1), 96'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("release_instr_ready", 96'(bus.instr_ready), 96'd1);
    tick();

    // ADDI x1,x0,-5 with one-cycle latency
    applyStimulus(32'hFFB00093, 1'b1,
                  mk(32'h0, 32'hFFFFFFFB, 5'd27, 1'b0, 3'b000, 7'h00, 5'd1));
    @(negedge clk);
    checkOutput("latency_valid", 96'(bus.issue_valid), 96'd1);
    waitDrain();

    // SRAI x2,x1,3 with R[1] = 0x80000000
    writeReg(5'd1, 32'h80000000);
    applyStimulus(32'h4030D113, 1'b1,
                  mk(32'h80000000, 32'h00000403, 5'd3, 1'b1, 3'b101, 7'h20, 5'd2));
    // ADDI x7,x0,0x400: immediate bit 30 must not become funct7
    applyStimulus(32'h40000393, 1'b1,
                  mk(32'h0, 32'h00000400, 5'd0, 1'b0, 3'b000, 7'h00, 5'd7));
    waitDrain();

    // Stall: third instruction waits until the ALU drains
    bus.issue_ready = 1'b0;
    applyStimulus(32'h00208233, 1'b1,
                  mk(32'h80000000, 32'h0, 5'd0, 1'b0, 3'b000, 7'h00, 5'd4));
    applyStimulus(32'h0010C2B3, 1'b1,
                  mk(32'h80000000, 32'h80000000, 5'd0, 1'b0, 3'b100, 7'h00, 5'd5));
    fork
      applyStimulus(32'h7FF06313, 1'b1,
                    mk(32'h0, 32'h000007FF, 5'd31, 1'b0, 3'b110, 7'h00, 5'd6));
      begin
        @(negedge clk);
        checkOutput("full_instr_ready", 96'(bus.instr_ready), 96'd0);
        tick();
        bus.issue_ready = 1'b1;
      end
    join
    waitDrain();

    // Writeback into stalled entries; immediates and x0 untouched
    bus.issue_ready = 1'b0;
    applyStimulus(32'h402081B3, 1'b1,
                  mk(32'h80000000, 32'h00000007, 5'd0, 1'b0, 3'b000, 7'h20, 5'd3));
    applyStimulus(32'h00200493, 1'b1,
                  mk(32'h0, 32'h00000002, 5'd2, 1'b0, 3'b000, 7'h00, 5'd9));
    writeReg(5'd2, 32'h00000007);
    writeReg(5'd0, 32'h12345678);
    bus.issue_ready = 1'b1;
    waitDrain();

    // Same-cycle writeback bypassed into operand read
    fork
      writeReg(5'd10, 32'hCAFEF00D);
      applyStimulus(32'h000505B3, 1'b1,
                    mk(32'hCAFEF00D, 32'h0, 5'd0, 1'b0, 3'b000, 7'h00, 5'd11));
    join
    waitDrain();

    // Illegal: JAL, OP with funct7 0000001, SLLI with funct7 0100000
    applyStimulus(32'h0000006F, 1'b0, '0);
    applyStimulus(32'h021080B3, 1'b0, '0);
    applyStimulus(32'h40109093, 1'b0, '0);
    repeat (3) tick();
    waitDrain();

    // Reset while holding two entries
    bus.issue_ready = 1'b0;
    applyStimulus(32'h00208233, 1'b1, '0);
    applyStimulus(32'h0010C2B3, 1'b1, '0);
    @(negedge clk);
    checkOutput("pre_reset_valid", 96'(bus.issue_valid), 96'd1);
    #2;
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    ill_pending = 0;
    checkOutput("async_reset_valid", 96'(bus.issue_valid), 96'd0);
    checkOutput("async_reset_payload",
                96'({bus.in1, bus.in2, bus.shamt, bus.use_shamt,
                     bus.funct3, bus.funct7, bus.rd, bus.illegal}), 96'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("post_reset_instr_ready", 96'(bus.instr_ready), 96'd1);
    checkOutput("post_reset_valid", 96'(bus.issue_valid), 96'd0);
    tick();
    bus.issue_ready = 1'b1;
    for (int r = 1; r < 32; r++) begin
      w = {7'b0000000, 5'(r), 5'(r), 3'b000, 5'd1, 7'b0110011};
      applyStimulus(w, 1'b1,
                    mk(32'h0, 32'h0, 5'd0, 1'b0, 3'b000, 7'h00, 5'd1));
    end
    waitDrain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
